// File: rtl/irrigation_pkg.sv
// Shared types and constants for the multi-zone irrigation controller.
// Scheduler states and tank level encodings.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATER    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [1:0] LVL_EMPTY = 2'b00;
    localparam logic [1:0] LVL_LOW   = 2'b01;
    localparam logic [1:0] LVL_MID   = 2'b10;
    localparam logic [1:0] LVL_FULL  = 2'b11;

endpackage

// File: rtl/zone_arbiter.sv
// Combinational round-robin pick over the zone request vector.
// The search starts at ptr and wraps modulo N_ZONES.
module zone_arbiter #(
    parameter  int N_ZONES = 4,
    localparam int IW      = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic [N_ZONES-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      grant,
    output logic               valid
);

    logic [2*N_ZONES-1:0] dbl;
    logic [N_ZONES-1:0]   rot;
    logic [IW-1:0]        off;
    logic [IW:0]          sum;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N_ZONES-1:0];
        off = '0;
        // Walk downwards so the smallest offset from ptr wins.
        for (int i = N_ZONES - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(N_ZONES)) sum = sum - (IW+1)'(N_ZONES);
        grant = sum[IW-1:0];
        valid = |req;
    end

endmodule

// File: rtl/irrigation_ctrl.sv
// Multi-zone irrigation scheduler with tank pump control.
// One zone is watered at a time; the pump latches a fault on timeout.
module irrigation_ctrl
    import irrigation_pkg::*;
#(
    parameter int N_ZONES      = 4,
    parameter int MOIST_W      = 8,
    parameter int DRY_TH       = 64,
    parameter int WET_TH       = 128,
    parameter int MAX_ON       = 16,
    parameter int GAP          = 4,
    parameter int PUMP_TIMEOUT = 64
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [N_ZONES*MOIST_W-1:0] Moisture_sensor,
    input  logic [1:0]                 Water_sensor,
    input  logic                       Enable,
    output logic                       Pump,
    output logic [N_ZONES-1:0]         Sprinkler,
    output logic                       Busy,
    output logic                       Fault
);

    localparam int IW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam int OW = (MAX_ON > 0) ? $clog2(MAX_ON + 1) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int PW = (PUMP_TIMEOUT > 0) ? $clog2(PUMP_TIMEOUT + 1) : 1;

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      zone;
    logic [OW-1:0]      on_cnt;
    logic [GW-1:0]      gap_cnt;
    logic [PW-1:0]      pump_cnt;
    logic [N_ZONES-1:0] req;
    logic [MOIST_W-1:0] cur_moist;
    logic [IW-1:0]      grant;
    logic               grant_valid;
    logic               stop;
    logic               on_last;
    logic               gap_last;
    logic               pump_last;
    logic               level_empty;

    always_comb begin
        req       = '0;
        cur_moist = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            req[i] = Moisture_sensor[i*MOIST_W +: MOIST_W] < MOIST_W'(DRY_TH);
            if (zone == IW'(i)) cur_moist = Moisture_sensor[i*MOIST_W +: MOIST_W];
        end
    end

    zone_arbiter #(
        .N_ZONES(N_ZONES)
    ) u_arb (
        .req  (req),
        .ptr  (ptr),
        .grant(grant),
        .valid(grant_valid)
    );

    assign level_empty = (Water_sensor == LVL_EMPTY);
    assign on_last     = on_cnt >= OW'(MAX_ON - 1);
    assign gap_last    = gap_cnt >= GW'(GAP - 1);
    assign pump_last   = pump_cnt >= PW'(PUMP_TIMEOUT - 1);
    assign stop        = (cur_moist >= MOIST_W'(WET_TH)) || on_last
                         || level_empty || !Enable;

    // Timeout beats a full tank on the same edge.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            Pump     <= 1'b0;
            Fault    <= 1'b0;
            pump_cnt <= '0;
        end else begin
            if (!Pump) pump_cnt <= '0;
            else if (pump_cnt != PW'(PUMP_TIMEOUT)) pump_cnt <= pump_cnt + PW'(1);
            if (Fault) begin
                Pump <= 1'b0;
            end else if (Pump && pump_last) begin
                Fault <= 1'b1;
                Pump  <= 1'b0;
            end else if (Water_sensor == LVL_FULL) begin
                Pump <= 1'b0;
            end else if (Water_sensor == LVL_EMPTY || Water_sensor == LVL_LOW) begin
                Pump <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            Sprinkler <= '0;
            Busy      <= 1'b0;
            ptr       <= '0;
            zone      <= '0;
            on_cnt    <= '0;
            gap_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Enable && !level_empty && grant_valid) begin
                        state     <= WATER;
                        Sprinkler <= N_ZONES'(1) << grant;
                        Busy      <= 1'b1;
                        zone      <= grant;
                        on_cnt    <= '0;
                        ptr       <= (grant == IW'(N_ZONES - 1)) ? '0 : grant + IW'(1);
                    end
                end
                WATER: begin
                    if (stop) begin
                        state     <= COOLDOWN;
                        Sprinkler <= '0;
                        gap_cnt   <= '0;
                    end else if (on_cnt != OW'(MAX_ON)) begin
                        on_cnt <= on_cnt + OW'(1);
                    end
                end
                COOLDOWN: begin
                    if (gap_last) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else if (gap_cnt != GW'(GAP)) begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    Sprinkler <= '0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/irrigation_ctrl.md
# irrigation_ctrl

Parametrised multi-zone irrigation and tank-fill controller for the smart-home automation top level. It generalises the single-zone water block to N moisture zones. Zones are served one at a time by a round-robin scheduler with moisture hysteresis, a maximum on-time and a cooldown gap. The tank pump has level hysteresis and a dry-run/timeout fault latch.

## Interface
Parameters:
- N_ZONES, 4, number of irrigation zones (≥1)
- MOIST_W, 8, width of each zone's moisture reading
- DRY_TH, 64, a zone requests water when its moisture is below this value
- WET_TH, 128, a zone is satisfied when its moisture is at or above this value; WET_TH > DRY_TH
- MAX_ON, 16, maximum cycles one zone's sprinkler stays on per service
- GAP, 4, cooldown cycles with all sprinklers off between services
- PUMP_TIMEOUT, 64, maximum continuous pump-on cycles before a fault is raised

Ports:
- CLK  in  1  system clock; all logic is on the rising edge
- Reset  in  1  asynchronous, active-low reset
- Moisture_sensor  in  N_ZONES*MOIST_W  packed zone readings; zone i is in bits [i*MOIST_W +: MOIST_W]
- Water_sensor  in  2  tank level: 00 empty, 01 low, 10 mid, 11 full
- Enable  in  1  irrigation enable; does not affect the pump
- Pump  out  1  tank fill pump
- Sprinkler  out  N_ZONES  one-hot zone valves, or all zero
- Busy  out  1  scheduler is not in IDLE
- Fault  out  1  pump timeout latched

## Operation
- Reset asserted (Reset=0): Pump=0, Sprinkler=0, Busy=0, Fault=0, FSM=IDLE, round-robin pointer=0. All counters are cleared. Outputs go low immediately, including mid-service.
- Pump:
  - Sets when Water_sensor ≤ 01 and Fault=0.
  - Clears when Water_sensor=11.
  - Holds its value at 10 (hysteresis).
  - An on-time counter runs while Pump=1 and clears when Pump is off.
  - When the counter reaches PUMP_TIMEOUT, Fault is set and Pump is cleared. Fault stays latched until Reset.
- Zone request: a zone requests when its reading < DRY_TH (unsigned compare).
- Scheduler FSM states:
  - IDLE: if Enable=1, Water_sensor≠00 and any zone requests, latch the round-robin winner, set its Sprinkler bit, load the on-time counter and go to WATER.
  - WATER: go to COOLDOWN and clear Sprinkler when any of these holds: the zone's reading ≥ WET_TH, the on-time reaches MAX_ON, Water_sensor=00, or Enable=0.
  - COOLDOWN: keep Sprinkler=0 for GAP cycles, then return to IDLE.
- Round-robin: the search starts at (last served zone + 1) mod N_ZONES. Zone 0 has first priority after reset. The pointer updates on entry to WATER.
- Fault does not inhibit the sprinklers. Irrigation continues while Water_sensor≠00.
- Counter widths: $clog2(MAX+1) of the respective limit. Counters saturate and never wrap.

## Timing
- Inputs are sampled at the rising edge. All outputs are registered.
- Latency is 1 cycle from the sampled condition to the output change: Pump set/clear, Sprinkler on/off, Fault set.
- WATER lasts at most MAX_ON cycles, with Sprinkler high for exactly MAX_ON edges on a timeout.
- COOLDOWN lasts exactly GAP cycles.
- Minimum period between sprinkler starts is MAX_ON+GAP+1 cycles when a zone is continuously dry.
- If a termination condition and a new request coincide in the same cycle, termination wins. The new request is served only after COOLDOWN.
- Fault set and Water_sensor=11 on the same edge: Pump=0 and Fault=1.
- Busy=1 in WATER and COOLDOWN.

## Structure
- Package irrigation_pkg holds:
  - the state enum (IDLE, WATER, COOLDOWN)
  - the level constants LVL_EMPTY, LVL_LOW, LVL_MID, LVL_FULL
- Sub-module zone_arbiter: combinational round-robin pick.
  - Inputs: request vector and pointer.
  - Outputs: grant index and valid.
  - Parametrised on N_ZONES.

## Test plan
- Reset=0 during WATER with Pump=1: Pump, Sprinkler, Busy and Fault go to 0 immediately. After release, IDLE with pointer=0.
- Water_sensor sequence 01→10→11: Pump=1 one edge after 01, stays 1 at 10, returns to 0 one edge after 11.
- Zone 2 reading 0x20, others 0xA0, level 10, Enable=1:
  - Sprinkler=0100 after one edge.
  - Zone 2 raised to 0x80: Sprinkler=0000 next edge, Busy=1 for 4 more cycles, then Busy=0.
- Zones 0 and 2 held at 0x10: zone 0 on for 16 cycles, 4-cycle gap, zone 2 on for 16, gap, then zone 0 again.
- Water_sensor held at 01 for 64 cycles: Fault=1 and Pump=0 at cycle 64. Both persist with level 01 until Reset.
- Level drops to 00 during WATER: Sprinkler=0 next edge, COOLDOWN entered. No new start while the level stays 00, even with dry zones.
